// File: rtl/lsu_load_queue.sv
// lsu_load_queue: in-order load queue plus a single registered store stage.
// Loads are queued at the tail. Each load is resolved at the head by ROB
// forwarding or by a data-cache request. Stores pass through one register to
// the ROB store port.
// Optional feature macro: LSU_LOAD_QUEUE_PERF_EN adds saturating perf counters.
module lsu_load_queue #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_BITS  = 32,
   parameter int unsigned R_WIDTH    = 6,
   parameter int unsigned MICROOP    = 5,
   parameter int unsigned ROB_TICKET = 3,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [MICROOP-1:0]     in_microop,
   input  logic [DATA_WIDTH-1:0]  in_base,
   input  logic [DATA_WIDTH-1:0]  in_imm,
   input  logic [DATA_WIDTH-1:0]  in_store_data,
   input  logic [ROB_TICKET-1:0]  in_ticket,
   input  logic [R_WIDTH-1:0]     in_dest,
   input  logic                   flush,
   output logic [ADDR_BITS-1:0]   frw_address,
   output logic [MICROOP-1:0]     frw_microop,
   input  logic [DATA_WIDTH-1:0]  frw_data,
   input  logic                   frw_valid,
   input  logic                   frw_stall,
   input  logic                   cache_writeback_valid,
   input  logic                   cache_load_blocked,
   output logic                   store_valid,
   output logic [ADDR_BITS-1:0]   store_address,
   output logic [DATA_WIDTH-1:0]  store_data,
   output logic [MICROOP-1:0]     store_microop,
   output logic [ROB_TICKET-1:0]  store_ticket,
   output logic                   cache_load_valid,
   output logic [ADDR_BITS-1:0]   cache_load_addr,
   output logic [R_WIDTH-1:0]     cache_load_dest,
   output logic [MICROOP-1:0]     cache_load_microop,
   output logic [ROB_TICKET-1:0]  cache_load_ticket,
   output logic                   fwd_valid,
   output logic [R_WIDTH-1:0]     fwd_dest,
   output logic [ROB_TICKET-1:0]  fwd_ticket,
   output logic [DATA_WIDTH-1:0]  fwd_data,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic                   busy_fu
`ifdef LSU_LOAD_QUEUE_PERF_EN
   ,
   output logic [31:0]            perf_fwd_cnt,
   output logic [31:0]            perf_cache_cnt,
   output logic [31:0]            perf_stall_cnt
`endif
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

   localparam logic [MICROOP-1:0] UopSb = MICROOP'(5'b00110);
   localparam logic [MICROOP-1:0] UopSh = MICROOP'(5'b00111);
   localparam logic [MICROOP-1:0] UopSw = MICROOP'(5'b01000);

   // Queue storage (not reset; validity is tracked by the pointers)
   logic [ADDR_BITS-1:0]  q_addr_q   [DEPTH];
   logic [MICROOP-1:0]    q_uop_q    [DEPTH];
   logic [ROB_TICKET-1:0] q_ticket_q [DEPTH];
   logic [R_WIDTH-1:0]    q_dest_q   [DEPTH];

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [OCC_W-1:0] occ_q, occ_d;

   logic                  st_valid_q, st_valid_d;
   logic [ADDR_BITS-1:0]  st_addr_q, st_addr_d;
   logic [DATA_WIDTH-1:0] st_data_q, st_data_d;
   logic [MICROOP-1:0]    st_uop_q, st_uop_d;
   logic [ROB_TICKET-1:0] st_ticket_q, st_ticket_d;

   logic [DATA_WIDTH-1:0] addr_sum;
   logic [ADDR_BITS-1:0]  in_addr;
   logic                  is_store, accept, push, pop, empty, head_ok, head_vis;

   assign addr_sum = in_base + in_imm;
   assign in_addr  = ADDR_BITS'(addr_sum);
   assign is_store = (in_microop == UopSb) | (in_microop == UopSh) | (in_microop == UopSw);
   assign empty    = (occ_q == '0);
   assign in_ready = (occ_q != OCC_W'(DEPTH)) & ~rst & ~flush;
   assign busy_fu  = ~in_ready;
   assign accept   = in_valid & in_ready;
   assign push     = accept & ~is_store;
   // Head is visible to the ROB search whenever loaded; it may only resolve
   // outside reset and flush.
   assign head_vis = ~empty & ~rst;
   assign head_ok  = head_vis & ~flush;

   assign frw_address = head_vis ? q_addr_q[head_q] : '0;
   assign frw_microop = head_vis ? q_uop_q[head_q]  : '0;
   assign occupancy   = rst ? '0 : occ_q;

   assign store_valid   = st_valid_q & ~rst;
   assign store_address = store_valid ? st_addr_q   : '0;
   assign store_data    = store_valid ? st_data_q   : '0;
   assign store_microop = store_valid ? st_uop_q    : '0;
   assign store_ticket  = store_valid ? st_ticket_q : '0;

   // Head resolution: forward hit, else stall, else cache request
   always_comb begin
      fwd_valid          = 1'b0;
      fwd_dest           = '0;
      fwd_ticket         = '0;
      fwd_data           = '0;
      cache_load_valid   = 1'b0;
      cache_load_addr    = '0;
      cache_load_dest    = '0;
      cache_load_microop = '0;
      cache_load_ticket  = '0;
      pop                = 1'b0;
      if (head_ok) begin
         if (frw_valid) begin
            fwd_valid = ~cache_writeback_valid & ~cache_load_blocked;
            pop       = fwd_valid;
            if (fwd_valid) begin
               fwd_dest   = q_dest_q[head_q];
               fwd_ticket = q_ticket_q[head_q];
               fwd_data   = frw_data;
            end
         end else if (!frw_stall) begin
            cache_load_valid = ~cache_writeback_valid;
            pop              = cache_load_valid & ~cache_load_blocked;
            if (cache_load_valid) begin
               cache_load_addr    = q_addr_q[head_q];
               cache_load_dest    = q_dest_q[head_q];
               cache_load_microop = q_uop_q[head_q];
               cache_load_ticket  = q_ticket_q[head_q];
            end
         end
      end
   end

   // Pointer, occupancy and store-stage next state; flush overrides all
   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      occ_d       = occ_q;
      st_valid_d  = accept & is_store;
      st_addr_d   = st_addr_q;
      st_data_d   = st_data_q;
      st_uop_d    = st_uop_q;
      st_ticket_d = st_ticket_q;
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      if (push && !pop)      occ_d = occ_q + OCC_W'(1);
      else if (pop && !push) occ_d = occ_q - OCC_W'(1);
      if (accept && is_store) begin
         st_addr_d   = in_addr;
         st_data_d   = in_store_data;
         st_uop_d    = in_microop;
         st_ticket_d = in_ticket;
      end
      if (flush) begin
         head_d      = '0;
         tail_d      = '0;
         occ_d       = '0;
         st_valid_d  = 1'b0;
         st_addr_d   = '0;
         st_data_d   = '0;
         st_uop_d    = '0;
         st_ticket_d = '0;
      end
   end

   // Control state register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         occ_q       <= '0;
         st_valid_q  <= 1'b0;
         st_addr_q   <= '0;
         st_data_q   <= '0;
         st_uop_q    <= '0;
         st_ticket_q <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         occ_q       <= occ_d;
         st_valid_q  <= st_valid_d;
         st_addr_q   <= st_addr_d;
         st_data_q   <= st_data_d;
         st_uop_q    <= st_uop_d;
         st_ticket_q <= st_ticket_d;
      end
   end

   // Write accepted loads at the tail
   always_ff @(posedge clk) begin
      if (push) begin
         q_addr_q[tail_q]   <= in_addr;
         q_uop_q[tail_q]    <= in_microop;
         q_ticket_q[tail_q] <= in_ticket;
         q_dest_q[tail_q]   <= in_dest;
      end
   end

`ifdef LSU_LOAD_QUEUE_PERF_EN
   logic fwd_pop, cache_pop, head_held;
   assign fwd_pop   = pop & fwd_valid;
   assign cache_pop = pop & cache_load_valid;
   // Any cycle a live head fails to leave counts as held
   assign head_held = head_ok & ~pop;

   // Saturating performance counters; only reset clears them
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fwd_cnt   <= '0;
         perf_cache_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (fwd_pop && perf_fwd_cnt != '1)     perf_fwd_cnt   <= perf_fwd_cnt + 32'd1;
         if (cache_pop && perf_cache_cnt != '1) perf_cache_cnt <= perf_cache_cnt + 32'd1;
         if (head_held && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_lsu_load_queue.sv
// Scoreboard bench for lsu_load_queue: stimulus pushes expected stores, cache
// loads and forwarded loads; a negedge monitor pops and compares them.
module tb_lsu_load_queue;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, flush;
   logic [4:0]  in_microop;
   logic [31:0] in_base, in_imm, in_store_data;
   logic [2:0]  in_ticket;
   logic [5:0]  in_dest;
   logic [31:0] frw_address;
   logic [4:0]  frw_microop;
   logic [31:0] frw_data;
   logic        frw_valid, frw_stall, cache_writeback_valid, cache_load_blocked;
   logic        store_valid;
   logic [31:0] store_address, store_data;
   logic [4:0]  store_microop;
   logic [2:0]  store_ticket;
   logic        cache_load_valid;
   logic [31:0] cache_load_addr;
   logic [5:0]  cache_load_dest;
   logic [4:0]  cache_load_microop;
   logic [2:0]  cache_load_ticket;
   logic        fwd_valid;
   logic [5:0]  fwd_dest;
   logic [2:0]  fwd_ticket;
   logic [31:0] fwd_data;
   logic [2:0]  occupancy;
   logic        busy_fu;

   lsu_load_queue dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_microop(in_microop), .in_base(in_base), .in_imm(in_imm),
      .in_store_data(in_store_data), .in_ticket(in_ticket), .in_dest(in_dest),
      .flush(flush), .frw_address(frw_address), .frw_microop(frw_microop),
      .frw_data(frw_data), .frw_valid(frw_valid), .frw_stall(frw_stall),
      .cache_writeback_valid(cache_writeback_valid),
      .cache_load_blocked(cache_load_blocked),
      .store_valid(store_valid), .store_address(store_address), .store_data(store_data),
      .store_microop(store_microop), .store_ticket(store_ticket),
      .cache_load_valid(cache_load_valid), .cache_load_addr(cache_load_addr),
      .cache_load_dest(cache_load_dest), .cache_load_microop(cache_load_microop),
      .cache_load_ticket(cache_load_ticket),
      .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_ticket(fwd_ticket),
      .fwd_data(fwd_data), .occupancy(occupancy), .busy_fu(busy_fu)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [4:0]  uop;
      logic [2:0]  tkt;
      logic [5:0]  dest;
   } exp_t;

   exp_t st_q[$];
   exp_t ld_q[$];
   exp_t fw_q[$];

   int checks = 0;
   int passed = 0;

   localparam int KNone = 0, KStore = 1, KCache = 2, KFwd = 3;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one operation and wait (bounded) until it is accepted
   task automatic issue(input logic [4:0] uop, input logic [31:0] base, input logic [31:0] imm,
                        input logic [31:0] data, input logic [2:0] tkt, input logic [5:0] dest,
                        input int kind);
      exp_t e;
      int   waited;
      e.addr = base + imm;
      e.data = data;
      e.uop  = uop;
      e.tkt  = tkt;
      e.dest = dest;
      if (kind == KStore) st_q.push_back(e);
      if (kind == KCache) ld_q.push_back(e);
      if (kind == KFwd)   fw_q.push_back(e);
      in_valid      = 1'b1;
      in_microop    = uop;
      in_base       = base;
      in_imm        = imm;
      in_store_data = (kind == KStore) ? data : 32'h0;
      in_ticket     = tkt;
      in_dest       = dest;
      waited        = 0;
      @(negedge clk);
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         checks++;
         $display("FAIL issue_timeout: in_ready got 0 expected 1 (t=%0t)", $time);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Monitor: compare every presented output against the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (store_valid) begin
            if (st_q.size() == 0) chk("unexpected_store", 64'd1, 64'd0);
            else begin
               e = st_q.pop_front();
               chk("store_address", 64'(store_address), 64'(e.addr));
               chk("store_data", 64'(store_data), 64'(e.data));
               chk("store_microop", 64'(store_microop), 64'(e.uop));
               chk("store_ticket", 64'(store_ticket), 64'(e.tkt));
            end
         end
         if (cache_load_valid) begin
            if (ld_q.size() == 0) chk("unexpected_cache_load", 64'd1, 64'd0);
            else begin
               e = ld_q[0];
               chk("cache_load_addr", 64'(cache_load_addr), 64'(e.addr));
               chk("cache_load_dest", 64'(cache_load_dest), 64'(e.dest));
               chk("cache_load_microop", 64'(cache_load_microop), 64'(e.uop));
               chk("cache_load_ticket", 64'(cache_load_ticket), 64'(e.tkt));
               if (!cache_load_blocked) void'(ld_q.pop_front());
            end
         end
         if (fwd_valid) begin
            if (fw_q.size() == 0) chk("unexpected_fwd", 64'd1, 64'd0);
            else begin
               e = fw_q.pop_front();
               chk("fwd_dest", 64'(fwd_dest), 64'(e.dest));
               chk("fwd_ticket", 64'(fwd_ticket), 64'(e.tkt));
               chk("fwd_data", 64'(fwd_data), 64'(e.data));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; in_microop = '0; in_base = '0;
      in_imm = '0; in_store_data = '0; in_ticket = '0; in_dest = '0;
      frw_data = '0; frw_valid = 1'b0; frw_stall = 1'b0;
      cache_writeback_valid = 1'b0; cache_load_blocked = 1'b0;

      // Reset state
      tick(); tick();
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_store_valid", 64'(store_valid), 64'd0);
      chk("rst_cache_load_valid", 64'(cache_load_valid), 64'd0);
      chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
      chk("rst_frw_address", 64'(frw_address), 64'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      chk("post_rst_busy_fu", 64'(busy_fu), 64'd0);
      tick();

      // Single load: 0x1000 + 0x10
      issue(5'b00000, 32'h1000, 32'h10, 32'h0, 3'd1, 6'd5, KCache);
      @(negedge clk);
      chk("ld1_valid_n1", 64'(cache_load_valid), 64'd1);
      chk("ld1_frw_address", 64'(frw_address), 64'h1010);
      chk("ld1_occ_n1", 64'(occupancy), 64'd1);
      tick();
      @(negedge clk);
      chk("ld1_occ_after", 64'(occupancy), 64'd0);
      chk("ld1_valid_after", 64'(cache_load_valid), 64'd0);
      tick();

      // Store: 0x20 + 4, data DEADBEEF
      issue(5'b00110, 32'h20, 32'h4, 32'hDEADBEEF, 3'd2, 6'd0, KStore);
      @(negedge clk);
      chk("st_valid_n1", 64'(store_valid), 64'd1);
      tick();
      @(negedge clk);
      chk("st_valid_n2", 64'(store_valid), 64'd0);
      tick();

      // Fill with frw_stall held, then drain in order
      frw_stall = 1'b1;
      for (int i = 0; i < 4; i++)
         issue(5'b00010, 32'h100, 32'(i * 4), 32'h0, 3'(3 + i), 6'(10 + i), KCache);
      @(negedge clk);
      chk("full_occ", 64'(occupancy), 64'd4);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_busy_fu", 64'(busy_fu), 64'd1);
      chk("full_stall_no_req", 64'(cache_load_valid), 64'd0);
      tick();
      frw_stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("drain_valid", 64'(cache_load_valid), 64'd1);
         chk("drain_occ", 64'(occupancy), 64'(4 - i));
         tick();
      end
      @(negedge clk);
      chk("drain_done_occ", 64'(occupancy), 64'd0);
      tick();

      // Forward hit held off by cache writeback for two cycles
      frw_valid = 1'b1; frw_data = 32'h55; cache_writeback_valid = 1'b1;
      issue(5'b00010, 32'h300, 32'h0, 32'h55, 3'd7, 6'd20, KFwd);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("fwd_hold_valid", 64'(fwd_valid), 64'd0);
         chk("fwd_hold_no_cache", 64'(cache_load_valid), 64'd0);
         chk("fwd_hold_occ", 64'(occupancy), 64'd1);
         tick();
      end
      cache_writeback_valid = 1'b0;
      @(negedge clk);
      chk("fwd_third_valid", 64'(fwd_valid), 64'd1);
      tick();
      frw_valid = 1'b0;
      @(negedge clk);
      chk("fwd_occ_after", 64'(occupancy), 64'd0);
      tick();

      // Cache port blocked for three cycles
      cache_load_blocked = 1'b1;
      issue(5'b00010, 32'h400, 32'h8, 32'h0, 3'd0, 6'd30, KCache);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("blk_valid", 64'(cache_load_valid), 64'd1);
         chk("blk_addr", 64'(cache_load_addr), 64'h408);
         chk("blk_occ", 64'(occupancy), 64'd1);
         tick();
      end
      cache_load_blocked = 1'b0;
      @(negedge clk);
      chk("unblk_valid", 64'(cache_load_valid), 64'd1);
      tick();
      @(negedge clk);
      chk("unblk_occ", 64'(occupancy), 64'd0);
      tick();

      // Flush with three queued loads and a pending store
      frw_stall = 1'b1;
      for (int i = 0; i < 3; i++)
         issue(5'b00010, 32'h600, 32'(i * 4), 32'h0, 3'(i), 6'(50 + i), KNone);
      issue(5'b00111, 32'h700, 32'h2, 32'hCAFE0001, 3'd6, 6'd0, KStore);
      flush = 1'b1; frw_stall = 1'b0;
      @(negedge clk);
      chk("flush_no_cache", 64'(cache_load_valid), 64'd0);
      chk("flush_no_fwd", 64'(fwd_valid), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      chk("flush_occ_before", 64'(occupancy), 64'd3);
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_occ_after", 64'(occupancy), 64'd0);
      chk("flush_store_valid", 64'(store_valid), 64'd0);
      chk("flush_cache_valid", 64'(cache_load_valid), 64'd0);
      tick();
      issue(5'b00010, 32'h500, 32'h20, 32'h0, 3'd4, 6'd40, KCache);
      @(negedge clk);
      chk("post_flush_valid", 64'(cache_load_valid), 64'd1);
      chk("post_flush_addr", 64'(cache_load_addr), 64'h520);
      tick();
      @(negedge clk);
      chk("post_flush_occ", 64'(occupancy), 64'd0);

      repeat (3) tick();
      chk("sb_store_drained", 64'(st_q.size()), 64'd0);
      chk("sb_load_drained", 64'(ld_q.size()), 64'd0);
      chk("sb_fwd_drained", 64'(fw_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/lsu_load_queue.md
# lsu_load_queue

Parametrised successor to the scalar load/store functional unit. Loads are held in a DEPTH-entry in-order queue, so forwarding stalls and cache-port hazards no longer block issue. Stores pass through a single registered stage to the ROB store interface. The block sits between issue and the non-blocking data cache, and drives the ROB forwarding search from the queue head.

## Interface
Parameters:
- DATA_WIDTH, 32: data and base-register width.
- ADDR_BITS, 32: address width.
- R_WIDTH, 6: destination register tag width.
- MICROOP, 5: micro-op width.
- ROB_TICKET, 3: ROB ticket width.
- DEPTH, 4: load queue entries; power of two, at least 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  queue can accept.
- in_microop  in  MICROOP  micro-op; stores are 5'b00110, 5'b00111, 5'b01000.
- in_base  in  DATA_WIDTH  rs1 value.
- in_imm  in  DATA_WIDTH  immediate.
- in_store_data  in  DATA_WIDTH  rs2 value.
- in_ticket  in  ROB_TICKET  ROB ticket.
- in_dest  in  R_WIDTH  destination tag.
- flush  in  1  discard all queued and in-flight operations.
- frw_address  out  ADDR_BITS  head-load address for the ROB search.
- frw_microop  out  MICROOP  head-load micro-op.
- frw_data  in  DATA_WIDTH  ROB forwarded data.
- frw_valid  in  1  ROB hit.
- frw_stall  in  1  unresolved older store.
- cache_writeback_valid  in  1  committed store using the cache port.
- cache_load_blocked  in  1  cache cannot take a load.
- store_valid, store_address, store_data, store_microop, store_ticket  out  1/ADDR_BITS/DATA_WIDTH/MICROOP/ROB_TICKET  store to ROB.
- cache_load_valid, cache_load_addr, cache_load_dest, cache_load_microop, cache_load_ticket  out  1/ADDR_BITS/R_WIDTH/MICROOP/ROB_TICKET  load to data cache.
- fwd_valid, fwd_dest, fwd_ticket, fwd_data  out  1/R_WIDTH/ROB_TICKET/DATA_WIDTH  forwarded-load writeback (raw word).
- occupancy  out  $clog2(DEPTH)+1  queued loads.
- busy_fu  out  1  equals ~in_ready.

## Operation
- Address is in_base + in_imm, truncated to ADDR_BITS with wrap-around and no overflow flag. It is computed at acceptance and stored.
- Acceptance occurs when in_valid & in_ready. in_ready = (occupancy != DEPTH) & ~rst & ~flush. in_ready applies to stores as well as loads.
- Store path: an accepted store loads the store register. store_valid is high for exactly the next cycle and carries the stored address, data, micro-op and ticket. The ROB always accepts, so there is no back-pressure.
- Load path: an accepted load is written at the tail; the pointer is DEPTH-modulo and wraps. Loads leave strictly in order from the head.
- frw_address and frw_microop reflect the head entry combinationally whenever the queue is non-empty, and are 0 when it is empty.
- Head resolution, evaluated in the same cycle:
  - frw_valid: fwd_valid = ~cache_writeback_valid & ~cache_load_blocked. fwd_data = frw_data; fwd_dest and fwd_ticket come from the head. The head pops when fwd_valid is asserted. No cache request is made.
  - else frw_stall: hold the head. No request and no pop.
  - else: cache_load_valid = ~cache_writeback_valid. The head pops when cache_load_valid & ~cache_load_blocked. A request rejected this way is re-presented the next cycle.
- Simultaneous push and pop leaves occupancy unchanged. A push on a full queue is impossible, because in_ready is low.
- Flush clears occupancy, pointers and the store register at the next edge, and takes priority over push and pop. fwd_valid and cache_load_valid are forced to 0 during the flush cycle.
- A ROB forwarding search by an older load ignores younger stores; this ordering is guaranteed by the ROB.

## Timing
- Reset: every output is 0 (in_ready is 0 while rst is high). Queue state is cleared. in_ready rises the first cycle after rst falls.
- A load accepted in cycle N can issue (cache or forward) in cycle N+1 at the earliest.
- A store accepted in cycle N has store_valid asserted in cycle N+1.
- Throughput is one load pop per cycle.
- Reset mid-operation discards all entries and the store register; no output fires in the cycle after reset.

## Configuration
- LSU_LOAD_QUEUE_PERF_EN defined: adds outputs perf_fwd_cnt, perf_cache_cnt and perf_stall_cnt, each 32 bits. They count fwd_valid pops, cache_load pops, and head cycles held by frw_stall or a port hazard. The counters saturate at all-ones and are cleared by rst (flush does not clear them).
- Macro undefined: those ports and counters do not exist.

## Test plan
- Single load at base 0x1000, imm 0x10, no hits or hazards: cache_load_valid at N+1 with addr 0x1010; occupancy returns to 0.
- Store at base 0x20, imm 4, data 0xDEADBEEF: store_valid for exactly one cycle at N+1 with address 0x24 and data 0xDEADBEEF.
- Fill DEPTH=4 loads with frw_stall held high: in_ready=0 and occupancy=4. Release frw_stall: four cache loads are issued in order on consecutive cycles.
- Head with frw_valid and frw_data 0x55 while cache_writeback_valid=1 for 2 cycles: no pop. Then fwd_valid=1 with fwd_data 0x55 in the third cycle.
- cache_load_blocked=1 for 3 cycles: cache_load_valid stays high with the same address and no pop; the pop happens on the first unblocked cycle.
- Flush with 3 queued loads and a pending store: the next cycle shows occupancy=0 and store_valid=0; a new load after flush is issued normally.
